// File: rtl/twos_to_signmag.sv
// twos_to_signmag: bit-serial two's-complement to sign-magnitude decoder.
// One word in, LSB-first conversion at one bit per clock, sign + magnitude out.
module twos_to_signmag #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_minneg
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-2:0] r_work;
    logic [CW-1:0]    r_cnt;
    logic             r_seen_one;
    logic             r_sign;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_out_sign;
    logic [WIDTH-1:0] r_out_mag;
    logic             r_out_minneg;

    logic             w_bit;
    logic             w_obit;
    logic             w_last;
    logic [WIDTH-1:0] w_work_nxt;

    // Negative words keep bits up to the first 1, then invert the rest.
    assign w_bit      = r_shift[0];
    assign w_obit     = (r_sign & r_seen_one) ? ~w_bit : w_bit;
    assign w_work_nxt = {w_obit, r_work};
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_sign   = r_out_sign;
    assign out_mag    = r_out_mag;
    assign out_minneg = r_out_minneg;

    // Control FSM and datapath: accept, shift WIDTH bits, hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_work       <= '0;
            r_cnt        <= '0;
            r_seen_one   <= 1'b0;
            r_sign       <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_sign   <= 1'b0;
            r_out_mag    <= '0;
            r_out_minneg <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shift    <= in_data;
                        r_sign     <= in_data[WIDTH-1];
                        r_work     <= '0;
                        r_cnt      <= '0;
                        r_seen_one <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_shift    <= r_shift >> 1;
                    r_work     <= w_work_nxt[WIDTH-1:1];
                    r_seen_one <= r_seen_one | w_bit;
                    r_cnt      <= r_cnt + CW'(1);
                    if (w_last) begin
                        // No 1 in the low bits of a negative word means -2^(W-1).
                        r_out_mag    <= w_work_nxt;
                        r_out_sign   <= r_sign;
                        r_out_minneg <= r_sign & ~r_seen_one;
                        r_out_valid  <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
